// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared encodings and history entry type for the write-back stage
package wb_pkg;

  // Result source select
  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2,
    WB_IMM = 2'd3
  } wb_sel_e;

  // Load size / signedness; codes 3, 6 and 7 are undefined and act as LW
  typedef enum logic [2:0] {
    LT_LB  = 3'd0,
    LT_LH  = 3'd1,
    LT_LW  = 3'd2,
    LT_LBU = 3'd4,
    LT_LHU = 3'd5
  } load_type_e;

  // History entries are sized for the widest supported datapath and register
  // file; a stage built with XLEN <= 64 and REG_AW <= 8 uses the low bits and
  // the unused upper bits are always written as zero.
  localparam int HIST_XLEN_MAX = 64;
  localparam int HIST_AW_MAX   = 8;

  typedef struct packed {
    logic                     valid;
    logic [HIST_AW_MAX-1:0]   rd;
    logic [HIST_XLEN_MAX-1:0] data;
  } hist_entry_t;

endpackage

// File: rtl/wb_load_align.sv
// rtl/wb_load_align.sv - combinational sub-word load aligner with sign/zero extension
module wb_load_align
  import wb_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] dm_data,
  input  logic [2:0]      load_type,
  input  logic [1:0]      byte_off,
  output logic [XLEN-1:0] aligned
);

  logic [XLEN-1:0] w_byte_sh;
  logic [XLEN-1:0] w_half_sh;

  // Shift the addressed byte / halfword down to bit 0; byte_off[0] is ignored for halves
  assign w_byte_sh = dm_data >> {byte_off, 3'b000};
  assign w_half_sh = dm_data >> {byte_off[1], 4'b0000};

  // Pick the extension for the load type; anything unrecognised passes the word through
  always_comb begin
    aligned = dm_data;
    case (load_type)
      LT_LB:   aligned = {{(XLEN-8){w_byte_sh[7]}}, w_byte_sh[7:0]};
      LT_LBU:  aligned = {{(XLEN-8){1'b0}}, w_byte_sh[7:0]};
      LT_LH:   aligned = {{(XLEN-16){w_half_sh[15]}}, w_half_sh[15:0]};
      LT_LHU:  aligned = {{(XLEN-16){1'b0}}, w_half_sh[15:0]};
      default: aligned = dm_data;
    endcase
  end

endmodule

// File: rtl/wb_stage_p.sv
// rtl/wb_stage_p.sv - write-back stage: result select, output register, write history, retire count
module wb_stage_p
  import wb_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int REG_AW     = 5,
  parameter int HIST_DEPTH = 4,
  parameter int CNT_W      = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_in,
  input  logic              stall,
  input  logic              flush,
  input  logic [REG_AW-1:0] rd_in,
  input  logic              reg_write_in,
  input  logic [1:0]        wb_sel,
  input  logic [2:0]        load_type,
  input  logic [1:0]        byte_off,
  input  logic [XLEN-1:0]   alu_data,
  input  logic [XLEN-1:0]   dm_data,
  input  logic [XLEN-1:0]   pc_plus4,
  input  logic [XLEN-1:0]   imm_data,
  output logic [XLEN-1:0]   wb_data,
  output logic [REG_AW-1:0] rd_out,
  output logic              reg_write_out,
  output logic              valid_out,
  input  logic [REG_AW-1:0] rs1_q,
  input  logic [REG_AW-1:0] rs2_q,
  output logic              hit1,
  output logic              hit2,
  output logic [XLEN-1:0]   fwd_data1,
  output logic [XLEN-1:0]   fwd_data2,
  output logic [CNT_W-1:0]  retire_count
);

  logic              w_accept;
  logic              w_write;
  logic [XLEN-1:0]   w_mem_data;
  logic [XLEN-1:0]   w_result;

  logic [XLEN-1:0]   r_wb_data;
  logic [REG_AW-1:0] r_rd;
  logic              r_reg_write;
  logic              r_valid;
  logic [CNT_W-1:0]  r_retire_count;
  hist_entry_t       r_hist [HIST_DEPTH];

  // flush dominates stall simply by both gating the same accept term
  assign w_accept = valid_in & ~stall & ~flush;
  assign w_write  = reg_write_in & (rd_in != '0);

  wb_load_align #(
    .XLEN (XLEN)
  ) u_load_align (
    .dm_data   (dm_data),
    .load_type (load_type),
    .byte_off  (byte_off),
    .aligned   (w_mem_data)
  );

  // Select the write-back result source
  always_comb begin
    w_result = alu_data;
    case (wb_sel)
      WB_ALU:  w_result = alu_data;
      WB_MEM:  w_result = w_mem_data;
      WB_PC4:  w_result = pc_plus4;
      WB_IMM:  w_result = imm_data;
      default: w_result = alu_data;
    endcase
  end

  // Output register: data and rd hold when nothing is accepted, strobes drop
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wb_data      <= '0;
      r_rd           <= '0;
      r_reg_write    <= 1'b0;
      r_valid        <= 1'b0;
      r_retire_count <= '0;
    end else begin
      r_reg_write <= w_accept & w_write;
      r_valid     <= w_accept;
      if (w_accept) begin
        r_wb_data      <= w_result;
        r_rd           <= rd_in;
        r_retire_count <= r_retire_count + CNT_W'(1);
      end
    end
  end

  // History shift register; only real register writes enter, so entry 0 tracks the output register
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < HIST_DEPTH; i++) begin
        r_hist[i] <= '0;
      end
    end else if (w_accept && w_write) begin
      for (int i = HIST_DEPTH - 1; i > 0; i--) begin
        r_hist[i] <= r_hist[i-1];
      end
      r_hist[0] <= '{valid: 1'b1,
                     rd:    HIST_AW_MAX'(rd_in),
                     data:  HIST_XLEN_MAX'(w_result)};
    end
  end

  // Forwarding lookup: scan oldest to newest so the newest match is the one left standing
  always_comb begin
    hit1      = 1'b0;
    hit2      = 1'b0;
    fwd_data1 = '0;
    fwd_data2 = '0;
    for (int i = HIST_DEPTH - 1; i >= 0; i--) begin
      if (r_hist[i].valid && (r_hist[i].rd == HIST_AW_MAX'(rs1_q)) && (rs1_q != '0)) begin
        hit1      = 1'b1;
        fwd_data1 = XLEN'(r_hist[i].data);
      end
      if (r_hist[i].valid && (r_hist[i].rd == HIST_AW_MAX'(rs2_q)) && (rs2_q != '0)) begin
        hit2      = 1'b1;
        fwd_data2 = XLEN'(r_hist[i].data);
      end
    end
  end

  assign wb_data       = r_wb_data;
  assign rd_out        = r_rd;
  assign reg_write_out = r_reg_write;
  assign valid_out     = r_valid;
  assign retire_count  = r_retire_count;

endmodule

// File: tb/tb_wb_stage_p.sv
// tb/tb_wb_stage_p.sv - directed self-checking bench for wb_stage_p
module tb_wb_stage_p;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_in;
  logic        stall;
  logic        flush;
  logic [4:0]  rd_in;
  logic        reg_write_in;
  logic [1:0]  wb_sel;
  logic [2:0]  load_type;
  logic [1:0]  byte_off;
  logic [31:0] alu_data;
  logic [31:0] dm_data;
  logic [31:0] pc_plus4;
  logic [31:0] imm_data;
  logic [31:0] wb_data;
  logic [4:0]  rd_out;
  logic        reg_write_out;
  logic        valid_out;
  logic [4:0]  rs1_q;
  logic [4:0]  rs2_q;
  logic        hit1;
  logic        hit2;
  logic [31:0] fwd_data1;
  logic [31:0] fwd_data2;
  logic [31:0] retire_count;

  int checks = 0;
  int errors = 0;

  wb_stage_p #(
    .XLEN       (32),
    .REG_AW     (5),
    .HIST_DEPTH (4),
    .CNT_W      (32)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .valid_in      (valid_in),
    .stall         (stall),
    .flush         (flush),
    .rd_in         (rd_in),
    .reg_write_in  (reg_write_in),
    .wb_sel        (wb_sel),
    .load_type     (load_type),
    .byte_off      (byte_off),
    .alu_data      (alu_data),
    .dm_data       (dm_data),
    .pc_plus4      (pc_plus4),
    .imm_data      (imm_data),
    .wb_data       (wb_data),
    .rd_out        (rd_out),
    .reg_write_out (reg_write_out),
    .valid_out     (valid_out),
    .rs1_q         (rs1_q),
    .rs2_q         (rs2_q),
    .hit1          (hit1),
    .hit2          (hit2),
    .fwd_data1     (fwd_data1),
    .fwd_data2     (fwd_data2),
    .retire_count  (retire_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] rd, input logic we, input logic [1:0] sel,
                       input logic [2:0] lt, input logic [1:0] off,
                       input logic [31:0] alu, input logic [31:0] dm,
                       input logic [31:0] pc4, input logic [31:0] imm);
    valid_in     = 1'b1;
    stall        = 1'b0;
    flush        = 1'b0;
    rd_in        = rd;
    reg_write_in = we;
    wb_sel       = sel;
    load_type    = lt;
    byte_off     = off;
    alu_data     = alu;
    dm_data      = dm;
    pc_plus4     = pc4;
    imm_data     = imm;
    step();
  endtask

  task automatic idle();
    valid_in = 1'b0;
    stall    = 1'b0;
    flush    = 1'b0;
    step();
  endtask

  task automatic pulse_reset();
    reset    = 1'b1;
    valid_in = 1'b0;
    step();
    reset    = 1'b0;
  endtask

  initial begin
    reset = 1'b1; valid_in = 1'b0; stall = 1'b0; flush = 1'b0;
    rd_in = '0; reg_write_in = 1'b0; wb_sel = '0; load_type = '0; byte_off = '0;
    alu_data = '0; dm_data = '0; pc_plus4 = '0; imm_data = '0;
    rs1_q = '0; rs2_q = '0;

    // reset state
    step(); step();
    chk("rst_wb_data", wb_data, 0);
    chk("rst_rd_out", rd_out, 0);
    chk("rst_reg_write", reg_write_out, 0);
    chk("rst_valid", valid_out, 0);
    chk("rst_retire", retire_count, 0);
    reset = 1'b0;
    rs1_q = 5'd3;
    step();
    chk("idle_hit1", hit1, 0);
    chk("idle_valid", valid_out, 0);
    chk("idle_retire", retire_count, 0);

    // load aligner through the MEM path
    issue(5'd1, 1'b1, 2'd1, 3'd0, 2'd2, 0, 32'h12F45678, 0, 0);
    chk("lb_off2", wb_data, 32'hFFFFFFF4);
    chk("lb_valid", valid_out, 1);
    chk("lb_we", reg_write_out, 1);
    chk("lb_rd", rd_out, 1);
    issue(5'd1, 1'b1, 2'd1, 3'd4, 2'd2, 0, 32'h12F45678, 0, 0);
    chk("lbu_off2", wb_data, 32'h000000F4);
    issue(5'd1, 1'b1, 2'd1, 3'd1, 2'd2, 0, 32'h12F45678, 0, 0);
    chk("lh_off2", wb_data, 32'h000012F4);
    issue(5'd1, 1'b1, 2'd1, 3'd1, 2'd3, 0, 32'h12F45678, 0, 0);
    chk("lh_off3", wb_data, 32'h000012F4);
    issue(5'd1, 1'b1, 2'd1, 3'd0, 2'd0, 0, 32'h12F45678, 0, 0);
    chk("lb_off0", wb_data, 32'h00000078);
    issue(5'd1, 1'b1, 2'd1, 3'd1, 2'd0, 0, 32'h12F48765, 0, 0);
    chk("lh_neg", wb_data, 32'hFFFF8765);
    issue(5'd1, 1'b1, 2'd1, 3'd5, 2'd0, 0, 32'h12F48765, 0, 0);
    chk("lhu", wb_data, 32'h00008765);
    issue(5'd1, 1'b1, 2'd1, 3'd3, 2'd1, 0, 32'h12F48765, 0, 0);
    chk("lt_undef", wb_data, 32'h12F48765);
    issue(5'd1, 1'b1, 2'd1, 3'd2, 2'd1, 0, 32'h12F48765, 0, 0);
    chk("lw", wb_data, 32'h12F48765);
    issue(5'd2, 1'b1, 2'd2, 3'd2, 2'd0, 32'h11, 32'h22, 32'h00001004, 32'h44);
    chk("sel_pc4", wb_data, 32'h00001004);
    issue(5'd2, 1'b1, 2'd3, 3'd2, 2'd0, 32'h11, 32'h22, 32'h33, 32'hDEAD0000);
    chk("sel_imm", wb_data, 32'hDEAD0000);
    chk("load_retire", retire_count, 11);

    // back-to-back writes, newest wins
    pulse_reset();
    issue(5'd5, 1'b1, 2'd0, 3'd2, 2'd0, 32'hA, 0, 0, 0);
    issue(5'd5, 1'b1, 2'd0, 3'd2, 2'd0, 32'hB, 0, 0, 0);
    issue(5'd6, 1'b1, 2'd0, 3'd2, 2'd0, 32'hC, 0, 0, 0);
    rs1_q = 5'd5;
    rs2_q = 5'd6;
    #1;
    chk("b2b_hit1", hit1, 1);
    chk("b2b_fwd1", fwd_data1, 32'hB);
    chk("b2b_hit2", hit2, 1);
    chk("b2b_fwd2", fwd_data2, 32'hC);
    chk("b2b_retire", retire_count, 3);
    idle();
    chk("idle2_valid", valid_out, 0);
    chk("idle2_we", reg_write_out, 0);
    chk("idle2_hold", wb_data, 32'hC);
    chk("idle2_fwd1", fwd_data1, 32'hB);

    // write to x0
    issue(5'd0, 1'b1, 2'd0, 3'd2, 2'd0, 32'h55, 0, 0, 0);
    rs1_q = 5'd0;
    #1;
    chk("x0_we", reg_write_out, 0);
    chk("x0_valid", valid_out, 1);
    chk("x0_data", wb_data, 32'h55);
    chk("x0_retire", retire_count, 4);
    chk("x0_hit1", hit1, 0);
    chk("x0_fwd1", fwd_data1, 0);

    // stall holds and never repeats the write
    issue(5'd7, 1'b1, 2'd0, 3'd2, 2'd0, 32'h77, 0, 0, 0);
    chk("st_we", reg_write_out, 1);
    chk("st_retire", retire_count, 5);
    rd_in    = 5'd9;
    alu_data = 32'h99;
    stall    = 1'b1;
    for (int k = 0; k < 2; k++) begin
      step();
      chk("stall_we", reg_write_out, 0);
      chk("stall_data", wb_data, 32'h77);
      chk("stall_rd", rd_out, 7);
      chk("stall_retire", retire_count, 5);
    end
    flush = 1'b1;
    rs1_q = 5'd9;
    step();
    chk("sf_we", reg_write_out, 0);
    chk("sf_valid", valid_out, 0);
    chk("sf_data", wb_data, 32'h77);
    chk("sf_retire", retire_count, 5);
    chk("sf_hit1", hit1, 0);
    stall = 1'b0;
    flush = 1'b0;
    step();
    chk("resume_data", wb_data, 32'h99);
    chk("resume_retire", retire_count, 6);
    chk("resume_fwd1", fwd_data1, 32'h99);

    // history depth: oldest drops
    pulse_reset();
    for (int i = 1; i <= 5; i++) begin
      issue(5'(i), 1'b1, 2'd0, 3'd2, 2'd0, 32'h100 + 32'(i), 0, 0, 0);
    end
    idle();
    for (int i = 1; i <= 5; i++) begin
      rs1_q = 5'(i);
      #1;
      if (i == 1) begin
        chk("depth_miss", hit1, 0);
      end else begin
        chk("depth_hit", hit1, 1);
        chk("depth_fwd", fwd_data1, 32'h100 + 32'(i));
      end
    end

    // reset mid-stream
    issue(5'd6, 1'b1, 2'd0, 3'd2, 2'd0, 32'h106, 0, 0, 0);
    reset    = 1'b1;
    rd_in    = 5'd7;
    alu_data = 32'h107;
    rs1_q    = 5'd6;
    rs2_q    = 5'd5;
    step();
    reset    = 1'b0;
    valid_in = 1'b0;
    chk("mrst_hit1", hit1, 0);
    chk("mrst_hit2", hit2, 0);
    chk("mrst_retire", retire_count, 0);
    chk("mrst_valid", valid_out, 0);
    chk("mrst_we", reg_write_out, 0);
    chk("mrst_data", wb_data, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_stage_p.md
# wb_stage_p

Parametrised write-back stage for the 5-stage pipeline. It registers the MEM/WB result for one cycle and drives the register-file write port. It selects the result source among ALU, data memory, PC+4 and immediate, and sign/zero-extends sub-word loads. It also keeps a short history of committed writes, so decode-stage forwarding can be resolved without the register file.

## Interface
Parameters:
- XLEN, 32, datapath width (≥16, multiple of 8)
- REG_AW, 5, register address width
- HIST_DEPTH, 4, committed-write history entries (≥1)
- CNT_W, 32, retire counter width

Ports:
- clk  in  1  single clock, all state on rising edge
- reset  in  1  synchronous, active-high
- valid_in  in  1  MEM/WB slot holds an instruction
- stall  in  1  do not capture input this cycle
- flush  in  1  kill input this cycle
- rd_in  in  REG_AW  destination register
- reg_write_in  in  1  instruction writes rd
- wb_sel  in  2  result source (ALU / MEM / PC4 / IMM)
- load_type  in  3  LB, LH, LW, LBU, LHU
- byte_off  in  2  low address bits of the load
- alu_data, dm_data, pc_plus4, imm_data  in  XLEN each  candidate results
- wb_data  out  XLEN  registered write data
- rd_out  out  REG_AW  registered destination
- reg_write_out  out  1  register-file write enable
- valid_out  out  1  output slot holds a retired instruction
- rs1_q, rs2_q  in  REG_AW  forwarding queries
- hit1, hit2  out  1  query matched history
- fwd_data1, fwd_data2  out  XLEN  newest matching data
- retire_count  out  CNT_W  retired instructions since reset

## Operation
- Accept = valid_in & ~stall & ~flush. On accept, the output register loads:
  - wb_data = the selected, extended result
  - rd_out = rd_in
  - reg_write_out = reg_write_in & (rd_in != 0)
  - valid_out = 1
- Result select:
  - ALU → alu_data; PC4 → pc_plus4; IMM → imm_data.
  - MEM → dm_data, passed through the load aligner.
- Load aligner:
  - LB/LBU take byte dm_data[8*byte_off +: 8].
  - LH/LHU take half dm_data[16*byte_off[1] +: 16]; byte_off[0] is ignored.
  - LB/LH sign-extend to XLEN; LBU/LHU zero-extend.
  - LW passes dm_data unchanged.
  - Undefined load_type codes behave as LW.
- No accept (stall, flush or ~valid_in): valid_out and reg_write_out become 0 next cycle; wb_data and rd_out hold. A stall never causes a duplicate write.
- flush has priority over stall; simultaneous assertion behaves as flush.
- History:
  - Shift register of {valid, rd, data}, HIST_DEPTH entries.
  - Entry 0 mirrors the current output register when reg_write_out = 1.
  - Each accept with reg_write_out-to-be = 1 shifts the history and inserts at the head. Other cycles leave it unchanged.
  - Writes to x0 never enter the history.
- Query:
  - Combinational: the newest valid entry with rd == rs_q wins.
  - rs_q == 0 → hit = 0, fwd_data = 0.
  - No match → hit = 0, fwd_data = 0.
- retire_count increments by 1 on every accept, including accepts with rd = 0 or reg_write_in = 0. It wraps modulo 2^CNT_W.

## Timing
- Latency: input to wb_data/reg_write_out is 1 cycle. Throughput is 1 per cycle.
- Forwarding lookup is zero-cycle (combinational) from the history registers.
- Reset value of every output on the cycle after reset = 1:
  - wb_data 0, rd_out 0, reg_write_out 0, valid_out 0, retire_count 0.
  - All history entries are invalid, so hit1/hit2 = 0.
- reset has priority over all inputs. Reset asserted mid-stream discards the in-flight instruction and all history.
- Back-to-back writes to the same rd: the history holds both entries; the query returns the newer one.
- History full: the oldest entry drops on shift; there is no overflow signal.

## Structure
- Shared package wb_pkg:
  - wb_sel encodings: WB_ALU = 0, WB_MEM = 1, WB_PC4 = 2, WB_IMM = 3.
  - load_type encodings: LT_LB = 0, LT_LH = 1, LT_LW = 2, LT_LBU = 4, LT_LHU = 5.
  - History entry struct.
- One combinational sub-module, wb_load_align (dm_data, load_type, byte_off → aligned XLEN), reusable by the memory stage.

## Test plan
- Reset, then idle: all outputs 0; hit1 = 0 for rs1_q = 3; retire_count = 0.
- LB, dm_data = 0x12F45678, byte_off = 2 → wb_data = 0xFFFFFFF4. The same with LBU → 0x000000F4. LH with byte_off = 2 → 0x000012F4.
- ALU write rd = 5, data = 0xA, then rd = 5, data = 0xB, then rd = 6, data = 0xC on consecutive cycles. Required: rs1_q = 5 → hit1 = 1, fwd_data1 = 0xB; rs2_q = 6 → fwd_data2 = 0xC; retire_count = 3.
- valid_in with rd = 0, reg_write_in = 1, ALU = 0x55 → reg_write_out = 0, no history entry, retire_count increments. rs1_q = 0 → hit1 = 0.
- Accept rd = 7, then hold stall = 1 for 2 cycles → reg_write_out pulses exactly once; wb_data holds; retire_count +1 only. Assert stall and flush together → treated as flush.
- HIST_DEPTH = 4: write rd = 1..5 in sequence → rd = 1 misses, rd = 2..5 hit. Assert reset mid-sequence → all hits clear and retire_count = 0 the next cycle.
